axi_write_master: RTL and testbench
===================================

# axi_write_master

Initiator side of the AXI3-style write path: it accepts a single-burst write command and a data stream from a local device, then drives the AW, W and B channels toward a write slave. It issues one address phase per command and streams exactly AWLEN+1 data beats with WLAST on the final beat. It then collects the write response and reports it to the device. The block sits between a device-side requester (DMA or cache writeback) and the interconnect / write-slave port.

## Interface
- buswidth, 32, data width in bits; WSTRB stays 4 bits wide and is driven to 4'hF.
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  device command request.
- cmd_ready  out  1  block is idle and can accept a command.
- cmd_id  in  4  transaction ID.
- cmd_addr  in  32  burst start address.
- cmd_len  in  4  number of beats minus 1 (0..15).
- cmd_size  in  3  bytes per beat, log2.
- cmd_burst  in  2  burst type (00 FIXED, 01 INCR, 10 WRAP).
- wdata_in  in  buswidth  device write data.
- wdata_valid  in  1  device data available.
- wdata_ready  out  1  block consumes wdata_in this cycle.
- done  out  1  one-cycle pulse when the transaction has completed.
- done_resp  out  2  BRESP captured for the completed transaction.
- id_err  out  1  with done: BID did not equal the issued ID.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  4/32/4/3/2  registered copies of the command.
- AWLOCK  out  2  tied to 0.
- AWCACHE  out  4  tied to 0.
- AWPROT  out  3  tied to 0.
- AWVALID  out  1  address valid.
- AWREADY  in  1  address ready.
- WID  out  4  equals the latched AWID.
- WDATA  out  buswidth  write data.
- WSTRB  out  4  driven to 4'hF.
- WLAST  out  1  marks the final beat.
- WVALID  out  1  data valid.
- WREADY  in  1  data ready.
- BID  in  4  response ID.
- BRESP  in  2  write response.
- BVALID  in  1  response valid.
- BREADY  out  1  response ready.

## Operation
- States: IDLE, ADDR, DATA, RESP. Encode as 2 bits.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch id, addr, len, size and burst into the AW registers.
  - Clear the beat counters and go to ADDR.
- ADDR:
  - AWVALID = 1, registered. It is held with stable payload until AWREADY.
  - On AWVALID & AWREADY: drop AWVALID and go to DATA.
  - W beats are never issued before the AW handshake completes.
- DATA:
  - 5-bit `sent` counts device beats loaded. 5-bit `acked` counts W handshakes.
  - wdata_ready = (state==DATA) & (sent <= AWLEN) & (!WVALID | WREADY). This path is combinational from WREADY.
  - On wdata_valid & wdata_ready:
    - WDATA <= wdata_in, WVALID <= 1, sent++.
    - WLAST <= (sent == AWLEN).
  - On WVALID & WREADY with no new load: WVALID <= 0 and WLAST <= 0.
  - A load and a handshake in the same cycle replace the beat back-to-back, with no bubble.
  - On a handshake with WLAST = 1: go to RESP. WVALID and WLAST clear the next cycle.
- RESP:
  - BREADY = 1.
  - On BVALID:
    - done <= 1, done_resp <= BRESP, id_err <= (BID != AWID).
    - Go to IDLE.
- Arithmetic:
  - Beat total = AWLEN+1, from 1 to 16.
  - Counters are 5 bits and never wrap inside a burst.
  - The master does not compute per-beat addresses; the slave increments them.
- Outside DATA: wdata_ready = 0. B-channel inputs are ignored when not in RESP.

## Timing
- Reset (ARESETn low at an edge):
  - State = IDLE.
  - AWVALID, WVALID, WLAST, BREADY, done, id_err = 0.
  - done_resp = 0. AW payload regs = 0. WDATA = 0.
  - Reset mid-burst aborts immediately; no WLAST is emitted.
- Command accepted at edge N → AWVALID high in cycle N+1.
- AWREADY high in cycle N+1 → state DATA from N+2. wdata_ready can be high in N+2. The earliest WVALID is in N+3.
- Steady stream (WREADY = 1, wdata_valid = 1): one beat per cycle.
- WVALID, WDATA and WLAST stay stable while WVALID & !WREADY.
- Last W handshake at edge M → BREADY high from M+1.
- B handshake at edge K:
  - done high in K+1 for exactly one cycle.
  - cmd_ready high in K+1.
  - A new cmd_valid in K+1 is accepted at that edge.
- A command of length 0 yields one beat with WLAST = 1 on its only beat.

## Test plan
- Single beat: cmd_len = 0, addr 0x100, id 3, all readies high → AWVALID for one cycle, one W beat with WLAST = 1 and WID = 3, done with done_resp = 00 and id_err = 0.
- 16-beat INCR: data 0..15, WREADY toggling 1/0 → exactly 16 W handshakes, in order, no duplicates; WLAST only on data 15.
- AWREADY delayed 5 cycles → AWVALID and payload stable; no WVALID before the AW handshake.
- BVALID delayed 4 cycles with BRESP = 10 and BID = 5 (issued ID 3) → BREADY held high; done pulse with done_resp = 10 and id_err = 1.
- Reset asserted on beat 4 of 8 → all outputs 0 next cycle, state IDLE; a new 2-beat command then completes normally.
- Back-to-back commands with cmd_valid held high → second accept one cycle after done; AW fields reflect the second command.

Source files
------------

// File: rtl/axi_write_master.sv
// AXI3-style single-burst write initiator: takes one command plus a device data
// stream, issues AW, streams AWLEN+1 W beats, then collects and reports B.
module axi_write_master #(
  parameter int buswidth = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // device command side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_id,
  input  logic [31:0]         cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  // device data side
  input  logic [buswidth-1:0] wdata_in,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  // completion report
  output logic                done,
  output logic [1:0]          done_resp,
  output logic                id_err,
  // AW channel
  output logic [3:0]          AWID,
  output logic [31:0]         AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic [1:0]          AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  // W channel
  output logic [3:0]          WID,
  output logic [buswidth-1:0] WDATA,
  output logic [3:0]          WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  // B channel
  input  logic [3:0]          BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state;
  logic [4:0] sent;   // device beats loaded into the W register
  logic [4:0] acked;  // W handshakes completed
  logic       load;
  logic       w_hs;

  assign cmd_ready   = (state == IDLE);
  // The W output register can take a new beat when empty or draining this cycle.
  assign wdata_ready = (state == DATA) && (sent <= {1'b0, AWLEN}) && (!WVALID || WREADY);
  assign load        = wdata_valid && wdata_ready;
  assign w_hs        = WVALID && WREADY;

  assign AWLOCK  = 2'b00;
  assign AWCACHE = 4'h0;
  assign AWPROT  = 3'b000;
  assign WID     = AWID;
  assign WSTRB   = 4'hF;

  // NOTE: all state uses non-blocking assignments and a synchronous reset so
  // every register samples the same pre-edge values and reset needs a clock.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      sent      <= '0;
      acked     <= '0;
      AWID      <= '0;
      AWADDR    <= '0;
      AWLEN     <= '0;
      AWSIZE    <= '0;
      AWBURST   <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WVALID    <= 1'b0;
      WLAST     <= 1'b0;
      BREADY    <= 1'b0;
      done      <= 1'b0;
      done_resp <= 2'b00;
      id_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            AWID    <= cmd_id;
            AWADDR  <= cmd_addr;
            AWLEN   <= cmd_len;
            AWSIZE  <= cmd_size;
            AWBURST <= cmd_burst;
            AWVALID <= 1'b1;
            sent    <= '0;
            acked   <= '0;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (load) begin
            WDATA  <= wdata_in;
            WVALID <= 1'b1;
            WLAST  <= (sent == {1'b0, AWLEN});
            sent   <= sent + 5'd1;
          end else if (w_hs) begin
            WVALID <= 1'b0;
            WLAST  <= 1'b0;
          end
          if (w_hs) begin
            acked <= acked + 5'd1;
            // No load can coincide with the final handshake: sent is past AWLEN.
            if (WLAST) begin
              BREADY <= 1'b1;
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (BVALID) begin
            done      <= 1'b1;
            done_resp <= BRESP;
            id_err    <= (BID != AWID);
            BREADY    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_master.sv
// Scenario bench for axi_write_master: inputs change on the falling edge and
// outputs are sampled 2 time units later, i.e. with the values the next rising edge sees.
module tb_axi_write_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [31:0] wdata_in;
  logic        wdata_valid;
  logic        wdata_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic        id_err;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [1:0]  AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } w_beat_t;

  typedef struct {
    logic [1:0] resp;
    logic       err;
  } b_exp_t;

  w_beat_t w_exp[$];
  b_exp_t  b_exp[$];

  always #5 ACLK = ~ACLK;

  axi_write_master #(.buswidth(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wdata_in(wdata_in), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .done(done), .done_resp(done_resp), .id_err(id_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  task automatic idle_inputs();
    cmd_valid = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
    wdata_in = 0; wdata_valid = 0; AWREADY = 0; WREADY = 0;
    BID = 0; BRESP = 0; BVALID = 0;
  endtask

  // Full transaction with a responsive slave model; W beats and the B report
  // are checked against the scoreboard queues filled here.
  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst,
                          input logic [31:0] dbase, input int aw_delay,
                          input bit wr_toggle, input int b_delay,
                          input logic [1:0] bresp, input logic [3:0] bid);
    for (int i = 0; i <= int'(len); i++)
      w_exp.push_back('{dbase + i, (i == int'(len)), id});
    b_exp.push_back('{bresp, (bid != id)});
    fork
      begin : cmd_side
        bit ok = 0;
        @(negedge ACLK);
        cmd_valid = 1; cmd_id = id; cmd_addr = addr; cmd_len = len;
        cmd_size = 3'd2; cmd_burst = burst;
        for (int t = 0; t < 100 && !ok; t++) begin
          if (t > 0) @(negedge ACLK);
          #2;
          ok = cmd_ready;
        end
        if (!ok) begin
          checks++; failures++;
          $display("FAIL cmd_accept_timeout: cmd_ready never seen");
        end
        @(negedge ACLK);
        cmd_valid = 0;
      end
      begin : data_side
        int i = 0;
        for (int t = 0; t < 400 && i <= int'(len); t++) begin
          @(negedge ACLK);
          wdata_valid = 1;
          wdata_in = dbase + i;
          #2;
          if (wdata_ready) i++;
        end
        if (i <= int'(len)) begin
          checks++; failures++;
          $display("FAIL wdata_timeout: loaded %0d beats, required %0d", i, int'(len) + 1);
        end
        @(negedge ACLK);
        wdata_valid = 0;
      end
      begin : aw_slave
        int cnt = 0;
        bit hs = 0;
        for (int t = 0; t < 200 && !hs; t++) begin
          @(negedge ACLK);
          AWREADY = (cnt >= aw_delay);
          #2;
          if (AWVALID) begin
            checks++;
            if (AWID !== id || AWADDR !== addr || AWLEN !== len || AWSIZE !== 3'd2 ||
                AWBURST !== burst || AWLOCK !== 2'b0 || AWCACHE !== 4'h0 || AWPROT !== 3'b0)
              begin
                failures++;
                $display("FAIL aw_payload: got id=%h addr=%h len=%h burst=%h, required id=%h addr=%h len=%h burst=%h",
                         AWID, AWADDR, AWLEN, AWBURST, id, addr, len, burst);
              end
            checks++;
            if (WVALID !== 1'b0) begin
              failures++;
              $display("FAIL w_before_aw: WVALID=%b during address phase, required 0", WVALID);
            end
            if (AWREADY) hs = 1;
            else cnt++;
          end
        end
        if (!hs) begin
          checks++; failures++;
          $display("FAIL aw_timeout: no AW handshake");
        end
        @(negedge ACLK);
        AWREADY = 0;
        #2;
        checks++;
        if (AWVALID !== 1'b0) begin
          failures++;
          $display("FAIL aw_drop: AWVALID=%b after handshake, required 0", AWVALID);
        end
      end
      begin : w_slave
        int cyc = 0;
        bit fin = 0;
        bit held = 0;
        logic [31:0] hd = '0;
        logic hl = 1'b0;
        w_beat_t e;
        for (int t = 0; t < 400 && !fin; t++) begin
          @(negedge ACLK);
          WREADY = wr_toggle ? cyc[0] : 1'b1;
          cyc++;
          #2;
          if (held) begin
            checks++;
            if (WVALID !== 1'b1 || WDATA !== hd || WLAST !== hl) begin
              failures++;
              $display("FAIL w_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                       WVALID, WDATA, WLAST, hd, hl);
            end
          end
          held = 0;
          if (WVALID && WREADY) begin
            checks++;
            if (w_exp.size() == 0) begin
              failures++;
              $display("FAIL w_extra: unexpected beat d=%h, required none", WDATA);
            end else begin
              e = w_exp.pop_front();
              if (WDATA !== e.data || WLAST !== e.last || WID !== e.id || WSTRB !== 4'hF) begin
                failures++;
                $display("FAIL w_beat: got d=%h l=%b id=%h strb=%h, required d=%h l=%b id=%h strb=f",
                         WDATA, WLAST, WID, WSTRB, e.data, e.last, e.id);
              end
              if (e.last) fin = 1;
            end
          end else if (WVALID) begin
            held = 1; hd = WDATA; hl = WLAST;
          end
        end
        if (!fin) begin
          checks++; failures++;
          $display("FAIL w_timeout: %0d beats still expected", w_exp.size());
        end
        @(negedge ACLK);
        WREADY = 0;
        #2;
        checks++;
        if (WVALID !== 1'b0 || WLAST !== 1'b0) begin
          failures++;
          $display("FAIL w_after_last: got v=%b l=%b, required 0 0", WVALID, WLAST);
        end
      end
      begin : b_slave
        bit seen = 0;
        b_exp_t e;
        for (int t = 0; t < 400 && !seen; t++) begin
          @(negedge ACLK);
          #2;
          seen = BREADY;
        end
        if (!seen) begin
          checks++; failures++;
          $display("FAIL bready_timeout: BREADY never seen");
        end
        for (int d = 0; d < b_delay; d++) begin
          @(negedge ACLK);
          #2;
          checks++;
          if (BREADY !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL bready_hold: got bready=%b done=%b, required 1 0", BREADY, done);
          end
        end
        @(negedge ACLK);
        BVALID = 1; BRESP = bresp; BID = bid;
        @(negedge ACLK);
        BVALID = 0; BRESP = 0; BID = 0;
        #2;
        e = b_exp.pop_front();
        checks++;
        if (done !== 1'b1 || done_resp !== e.resp || id_err !== e.err) begin
          failures++;
          $display("FAIL done_report: got done=%b resp=%b err=%b, required 1 %b %b",
                   done, done_resp, id_err, e.resp, e.err);
        end
        checks++;
        if (cmd_ready !== 1'b1 || BREADY !== 1'b0) begin
          failures++;
          $display("FAIL post_done: got cmd_ready=%b bready=%b, required 1 0", cmd_ready, BREADY);
        end
        @(negedge ACLK);
        #2;
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL done_pulse: done=%b second cycle, required 0", done);
        end
      end
    join
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (AWVALID !== 0 || WVALID !== 0 || WLAST !== 0 || BREADY !== 0 || done !== 0 ||
        id_err !== 0 || done_resp !== 0) begin
      failures++;
      $display("FAIL %s_ctrl: got awv=%b wv=%b wl=%b br=%b done=%b err=%b resp=%b, required all 0",
               tag, AWVALID, WVALID, WLAST, BREADY, done, id_err, done_resp);
    end
    checks++;
    if (AWID !== 0 || AWADDR !== 0 || AWLEN !== 0 || AWSIZE !== 0 || AWBURST !== 0 || WDATA !== 0) begin
      failures++;
      $display("FAIL %s_payload: got id=%h addr=%h len=%h wdata=%h, required 0",
               tag, AWID, AWADDR, AWLEN, WDATA);
    end
    checks++;
    if (cmd_ready !== 1'b1 || wdata_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: got cmd_ready=%b wdata_ready=%b, required 1 0",
               tag, cmd_ready, wdata_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    #2;
    check_all_zero("reset");
    @(negedge ACLK);
    ARESETn = 1;
  endtask

  task automatic test_single_beat();
    do_burst(4'd3, 32'h100, 4'd0, 2'b01, 32'hD000_0000, 0, 1'b0, 0, 2'b00, 4'd3);
  endtask

  task automatic test_incr16_toggle();
    do_burst(4'd6, 32'h1000, 4'd15, 2'b01, 32'd0, 0, 1'b1, 0, 2'b00, 4'd6);
  endtask

  task automatic test_aw_delay();
    do_burst(4'd2, 32'h2468, 4'd3, 2'b10, 32'h0000_0A00, 5, 1'b0, 0, 2'b01, 4'd2);
  endtask

  task automatic test_b_delay();
    do_burst(4'd3, 32'h500, 4'd1, 2'b00, 32'h0000_0B00, 0, 1'b0, 4, 2'b10, 4'd5);
  endtask

  task automatic test_reset_mid_burst();
    int hs = 0;
    int k = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_id = 4'd7; cmd_addr = 32'h2000; cmd_len = 4'd7;
    cmd_size = 3'd2; cmd_burst = 2'b01;
    AWREADY = 1; WREADY = 1; wdata_valid = 1; wdata_in = 32'hA0;
    #2;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_accept: cmd_ready=%b, required 1", cmd_ready);
    end
    for (int t = 0; t < 100 && hs < 4; t++) begin
      @(negedge ACLK);
      cmd_valid = 0;
      wdata_in = 32'hA0 + k;
      #2;
      if (wdata_ready) k++;
      if (WVALID && WREADY) begin
        hs++;
        checks++;
        if (WLAST !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid_wlast: WLAST=%b on beat %0d of 8, required 0", WLAST, hs);
        end
      end
    end
    if (hs < 4) begin
      checks++; failures++;
      $display("FAIL rst_mid_timeout: %0d beats, required 4", hs);
    end
    @(negedge ACLK);
    ARESETn = 0;
    @(negedge ACLK);
    idle_inputs();
    #2;
    check_all_zero("rst_mid");
    @(negedge ACLK);
    ARESETn = 1;
    do_burst(4'd4, 32'h3000, 4'd1, 2'b01, 32'h0000_0C00, 0, 1'b0, 0, 2'b00, 4'd4);
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_id = 4'd1; cmd_addr = 32'h3000; cmd_len = 4'd1;
    cmd_size = 3'd2; cmd_burst = 2'b01;
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b00; BID = 4'd1;
    wdata_valid = 1; wdata_in = 32'h55;
    @(negedge ACLK);
    cmd_id = 4'd9; cmd_addr = 32'h4000; cmd_len = 4'd2; cmd_burst = 2'b10;
    for (int t = 0; t < 50 && !seen; t++) begin
      if (t > 0) @(negedge ACLK);
      #2;
      seen = done;
    end
    checks++;
    if (!seen || cmd_ready !== 1'b1 || done_resp !== 2'b00 || id_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first_done: got done=%b cmd_ready=%b resp=%b err=%b, required 1 1 00 0",
               seen, cmd_ready, done_resp, id_err);
    end
    @(negedge ACLK);
    cmd_valid = 0;
    #2;
    checks++;
    if (AWVALID !== 1'b1 || AWID !== 4'd9 || AWADDR !== 32'h4000 || AWLEN !== 4'd2 ||
        AWBURST !== 2'b10 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_aw: got awv=%b id=%h addr=%h len=%h burst=%b done=%b, required 1 9 4000 2 10 0",
               AWVALID, AWID, AWADDR, AWLEN, AWBURST, done);
    end
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge ACLK);
      #2;
      seen = done;
    end
    checks++;
    if (!seen || done_resp !== 2'b00 || id_err !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_done: got done=%b resp=%b err=%b, required 1 00 1",
               seen, done_resp, id_err);
    end
    @(negedge ACLK);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    ARESETn = 0;
    test_reset();
    test_single_beat();
    test_incr16_toggle();
    test_aw_delay();
    test_b_delay();
    test_reset_mid_burst();
    test_back_to_back();
    checks++;
    if (w_exp.size() != 0 || b_exp.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d W and %0d B entries left, required 0",
               w_exp.size(), b_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
